// File: rtl/cpu_header_add.sv
// Prepends a CPU header beat (built from first-beat tuser) to each AXI-Stream packet.
// Optional statistics counters are enabled by defining CPU_HEADER_ADD_STATS_EN.
module cpu_header_add #(
  parameter int C_DATA_WIDTH  = 256,
  parameter int C_TUSER_WIDTH = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready
`ifdef CPU_HEADER_ADD_STATS_EN
  ,
  output logic [31:0]               pkt_cnt,
  output logic [31:0]               beat_cnt
`endif
);

  typedef enum logic {IDLE, PLD} state_t;

  state_t                  state;
  logic                    ld;
  logic [C_DATA_WIDTH-1:0] hdr_data;

  assign ld            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == PLD) && ld;

  always_comb begin
    hdr_data = '0;
    hdr_data[C_TUSER_WIDTH-1:0] = s_axis_tuser;
  end

  // In IDLE the first upstream beat is only peeked to build the header; it is consumed in PLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (ld) begin
      case (state)
        IDLE: begin
          if (s_axis_tvalid) begin
            m_axis_tdata  <= hdr_data;
            m_axis_tkeep  <= '1;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            state         <= PLD;
          end else begin
            m_axis_tvalid <= 1'b0;
          end
        end
        PLD: begin
          if (s_axis_tvalid) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= 1'b1;
            if (s_axis_tlast)
              state <= IDLE;
          end else begin
            m_axis_tvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CPU_HEADER_ADD_STATS_EN
  logic hdr_beat;

  // Tracks whether the beat currently held in the output register is a header.
  always_ff @(posedge clk) begin
    if (rst)
      hdr_beat <= 1'b0;
    else if (ld)
      hdr_beat <= (state == IDLE) && s_axis_tvalid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        pkt_cnt <= pkt_cnt + 32'd1;
      if (m_axis_tvalid && m_axis_tready && !hdr_beat)
        beat_cnt <= beat_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_header_add.sv
// Self-checking bench for cpu_header_add: directed table, random backpressure, reset and stats.
module tb_cpu_header_add;

  localparam int DW = 256;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [DW-1:0] s_tuser = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
`ifdef CPU_HEADER_ADD_STATS_EN
  logic [31:0]   pkt_cnt;
  logic [31:0]   beat_cnt;
`endif

  cpu_header_add #(.C_DATA_WIDTH(DW), .C_TUSER_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser), .s_axis_tkeep(s_tkeep),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready)
`ifdef CPU_HEADER_ADD_STATS_EN
    , .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; logic [DW-1:0] user; } ib_t;
  typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } ob_t;
  typedef struct { logic [7:0] user; int nbeats; logic [KW-1:0] keep_last; logic [7:0] exp_hdr; int exp_beats; } vec_t;

  ib_t        pkt[$];
  ob_t        exp_q[$];
  logic [7:0] hdr_q[$];
  int         beats_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         rdy_mode = 0;
  bit         mon_en = 1'b0;
  bit         in_pkt = 1'b0;
  int         cnt = 0;
  bit         pstall = 1'b0;
  logic [DW+KW:0] pbeat;

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW+KW:0] act, input logic [DW+KW:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream ready generator: 0 = always ready, 1 = random 50%, 2 = driven by directed code.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) m_tready = 1'b1;
      else if (rdy_mode == 1) m_tready = ($urandom_range(1) == 1);
    end
  end

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    if (!mon_en || rst) begin
      pstall = 1'b0; in_pkt = 1'b0; cnt = 0;
    end else begin
      if (pstall) begin
        n_chk++;
        if (m_tvalid !== 1'b1 || {m_tdata, m_tkeep, m_tlast} !== pbeat) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b %h expected v=1 %h", m_tvalid, {m_tdata, m_tkeep, m_tlast}, pbeat);
        end
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_beat: got %h expected none", m_tdata);
        end else begin
          ob_t e;
          e = exp_q.pop_front();
          chk("out_beat", {m_tdata, m_tkeep, m_tlast}, {e.data, e.keep, e.last});
        end
        if (!in_pkt) begin hdr_q.push_back(m_tdata[7:0]); in_pkt = 1'b1; end
        cnt++;
        if (m_tlast) begin beats_q.push_back(cnt); cnt = 0; in_pkt = 1'b0; end
      end
      pstall = m_tvalid && !m_tready;
      pbeat  = {m_tdata, m_tkeep, m_tlast};
    end
  end

  task automatic send_pkt(input int gap_pct);
    ob_t o;
    bit  acc;
    o.data = pkt[0].user; o.keep = '1; o.last = 1'b0;
    exp_q.push_back(o);
    foreach (pkt[i]) begin
      o.data = pkt[i].data; o.keep = pkt[i].keep; o.last = pkt[i].last;
      exp_q.push_back(o);
    end
    foreach (pkt[i]) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_tvalid = 1'b0; @(posedge clk); #1;
      end
      s_tdata = pkt[i].data; s_tkeep = pkt[i].keep; s_tlast = pkt[i].last;
      s_tuser = pkt[i].user; s_tvalid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 2000 && !acc; t++) begin
        @(negedge clk); acc = s_tready;
        @(posedge clk); #1;
      end
      n_chk++;
      if (!acc) begin
        n_fail++;
        $display("FAIL accept_timeout: got no handshake expected beat %0d accepted", i);
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic build_pkt(input logic [DW-1:0] user, input int nb, input logic [KW-1:0] keep_last);
    ib_t b;
    pkt.delete();
    for (int i = 0; i < nb; i++) begin
      b.data = rand256(); b.user = user; b.last = (i == nb - 1);
      b.keep = (i == nb - 1) ? keep_last : '1;
      pkt.push_back(b);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 5000 && exp_q.size() != 0; t++) @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0; rst = 1'b1; s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete(); hdr_q.delete(); beats_q.delete();
    mon_en = 1'b1;
  endtask

  vec_t tbl[3];

  initial begin
    tbl[0] = '{8'hA5, 3, '1,          8'hA5, 4};
    tbl[1] = '{8'h11, 1, 32'h0000000F, 8'h11, 2};
    tbl[2] = '{8'h22, 2, '1,          8'h22, 3};

    rdy_mode = 0;
    do_reset();
    @(negedge clk);
    chk("rst_tvalid", {{(DW+KW){1'b0}}, m_tvalid}, '0);
    chk("rst_tdata_tkeep_tlast", {m_tdata, m_tkeep, m_tlast}, '0);
    chk("rst_s_tready", {{(DW+KW){1'b0}}, s_tready}, '0);
    @(posedge clk); #1;

    // Directed table: back-to-back packets, full rate.
    foreach (tbl[k]) begin
      build_pkt({{(DW-8){1'b0}}, tbl[k].user}, tbl[k].nbeats, tbl[k].keep_last);
      send_pkt(0);
    end
    drain();
    foreach (tbl[k]) begin
      int nb;
      logic [7:0] h;
      nb = (beats_q.size() != 0) ? beats_q.pop_front() : -1;
      h  = (hdr_q.size() != 0) ? hdr_q.pop_front() : 8'hxx;
      chk("tbl_out_beats", DW'(nb), DW'(tbl[k].exp_beats));
      chk("tbl_hdr_byte", DW'(h), DW'(tbl[k].exp_hdr));
    end

    // tuser changes after the first beat must not affect the header.
    build_pkt(256'h5A, 3, '1);
    pkt[1].user = 256'hFF;
    pkt[2].user = 256'h00;
    send_pkt(0);
    drain();

    // Random backpressure and upstream gaps.
    rdy_mode = 1;
    for (int p = 0; p < 100; p++) begin
      build_pkt(rand256(), $urandom_range(10, 1), KW'($urandom));
      send_pkt(20);
    end
    drain();
    rdy_mode = 0;
    drain();

    // Reset during beat 2 of a 4-beat packet while stalled.
    mon_en = 1'b0; rdy_mode = 2; m_tready = 1'b1;
    exp_q.delete();
    s_tdata = rand256(); s_tuser = 256'h77; s_tkeep = '1; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_hdr_out", {m_tvalid, m_tdata[7:0]}, {1'b1, 8'h77});
    @(posedge clk); #1;
    s_tdata = rand256(); m_tready = 1'b0;
    @(negedge clk);
    chk("mid_stall_s_tready", {{(DW+KW){1'b0}}, s_tready}, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid_s_tready", {m_tvalid, s_tready}, '0);
    @(posedge clk); #1;
    exp_q.delete(); hdr_q.delete(); beats_q.delete();
    mon_en = 1'b1; rdy_mode = 0;
    build_pkt(256'h3C, 2, 32'h00FF00FF);
    send_pkt(0);
    drain();
    chk("post_rst_hdr", DW'(hdr_q.size() != 0 ? hdr_q.pop_front() : 8'hxx), DW'(8'h3C));

`ifdef CPU_HEADER_ADD_STATS_EN
    do_reset();
    for (int p = 0; p < 5; p++) begin
      build_pkt(DW'(p), 3, '1);
      send_pkt(0);
    end
    drain();
    chk("stats_pkt_cnt", DW'(pkt_cnt), DW'(5));
    chk("stats_beat_cnt", DW'(beat_cnt), DW'(15));
    @(negedge clk);
    force dut.pkt_cnt = 32'hFFFFFFFF;
    force dut.beat_cnt = 32'hFFFFFFFF;
    #1;
    release dut.pkt_cnt;
    release dut.beat_cnt;
    @(posedge clk); #1;
    build_pkt(256'h9, 1, '1);
    send_pkt(0);
    drain();
    chk("stats_pkt_wrap", DW'(pkt_cnt), DW'(0));
    chk("stats_beat_wrap", DW'(beat_cnt), DW'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
